// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and pointer-width helper.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  // One spare MSB lets wrapped pointers tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read; contents are never reset.
module fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// First-word-fall-through FIFO, valid/ready both sides; a pushed word is readable the next cycle.
// Full stalls the writer, empty stalls the reader; FIFO_FLUSH_EN adds a synchronous flush port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   nRST,
`ifdef FIFO_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THR   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR   = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          push, pop, ram_we;

  assign count    = wr_ptr - rd_ptr;
  assign wr_ready = (count != FULL_CNT);
  assign rd_valid = (count != '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    ram_we     = push;
`ifdef FIFO_FLUSH_EN
    // Flush wins over any push or pop in the same cycle.
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      ram_we     = 1'b0;
    end
`endif
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Flags come from the next count so they line up with count itself.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      almost_full  <= (count_nxt >= AF_THR);
      almost_empty <= (count_nxt <= AE_THR);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1) against a queue model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk;
  logic          nRST;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [2:0]    count;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] tmp;

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
`ifdef FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every visible output follows from the number and order of stored words.
  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(n != DP));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
    if (n != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  // Called with clk low; returns at the following falling edge after checking.
  task automatic cycle(input string tag, input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic m_push, m_pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    m_push = wv && (q.size() < DP);
    m_pop  = rr && (q.size() != 0);
    @(posedge clk);
    if (m_pop) tmp = q.pop_front();
    if (m_push) q.push_back(wd);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [DW-1:0] exp_pop [4];
    exp_pop[0] = 8'h11; exp_pop[1] = 8'h22; exp_pop[2] = 8'h33; exp_pop[3] = 8'h44;
    nRST = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
`ifdef FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    #12;
    check_state("reset");
    @(negedge clk);
    nRST = 1'b1;
    check_state("post_reset");

    // Fill with four known words.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, exp_pop[i], 1'b0);
    chk("full.wr_ready", 32'(wr_ready), 32'd0);
    chk("full.count", 32'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      chk("drain.data", 32'(rd_data), 32'(exp_pop[i]));
      cycle("drain", 1'b0, 8'h00, 1'b1);
    end
    chk("empty.rd_valid", 32'(rd_valid), 32'd0);
    chk("empty.almost_empty", 32'(almost_empty), 32'd1);

    // Steady push+pop at count 2; pointers wrap more than once.
    cycle("pp_pre", 1'b1, 8'hA1, 1'b0);
    cycle("pp_pre", 1'b1, 8'hA2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("pushpop", 1'b1, 8'($urandom), 1'b1);
      chk("pushpop.count2", 32'(count), 32'd2);
    end

    // Write offered while full: only the pop happens, the write lands next cycle.
    cycle("refill", 1'b1, 8'hB3, 1'b0);
    cycle("refill", 1'b1, 8'hB4, 1'b0);
    chk("refill.wr_ready", 32'(wr_ready), 32'd0);
    cycle("full_wr_rd", 1'b1, 8'hA5, 1'b1);
    chk("full_wr_rd.count", 32'(count), 32'd3);
    cycle("held_wr", 1'b1, 8'hA5, 1'b0);
    chk("held_wr.count", 32'(count), 32'd4);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Bring to count 3, then reset between edges.
    for (int i = 0; i < 4; i++) cycle("pre_rst_drain", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle("pre_rst_fill", 1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre_rst.count", 32'(count), 32'd3);
    #1 nRST = 1'b0;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rst.wr_ready", 32'(wr_ready), 32'd1);
    chk("async_rst.almost_empty", 32'(almost_empty), 32'd1);
    chk("async_rst.almost_full", 32'(almost_full), 32'd0);
    q.delete();
    #1 nRST = 1'b1;
    cycle("post_rst_push", 1'b1, 8'h9C, 1'b0);

`ifdef FIFO_FLUSH_EN
    cycle("pre_flush", 1'b1, 8'h5A, 1'b0);
    chk("pre_flush.count", 32'(count), 32'd2);
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    flush    = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    flush    = 1'b0;
    wr_valid = 1'b0;
    check_state("flush");
    chk("flush.count", 32'(count), 32'd0);
    cycle("post_flush", 1'b1, 8'h7E, 1'b0);
    chk("post_flush.data", 32'(rd_data), 32'h7E);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one data word.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries; power of two, at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_valid  input  1  producer offers wr_data.
REQ-008 SHALL have port wr_ready  output  1  FIFO can accept a word.
REQ-009 SHALL have port wr_data  input  DATA_W  write word.
REQ-010 SHALL have port rd_valid  output  1  head word present on rd_data.
REQ-011 SHALL have port rd_ready  input  1  consumer takes the head word.
REQ-012 SHALL have port rd_data  output  DATA_W  head word (first-word-fall-through).
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-014 SHALL have ports almost_full and almost_empty  output  1  threshold flags.
REQ-015 SHALL have port flush  input  1  synchronous clear; present only when FIFO_FLUSH_EN is defined.

Function
REQ-016 SHALL define push = wr_valid & wr_ready and pop = rd_valid & rd_ready.
REQ-017 SHALL drive wr_ready = (count != DEPTH) and rd_valid = (count != 0), both decoded from registered state.
REQ-018 SHALL keep write and read pointers of $clog2(DEPTH)+1 bits: increment by one on push/pop respectively, wrap naturally, and address the RAM with the low $clog2(DEPTH) bits.
REQ-019 SHALL compute count = wr_ptr - rd_ptr modulo 2^($clog2(DEPTH)+1): full when MSBs differ and low bits match; empty when pointers are equal.
REQ-020 SHALL write wr_data at wr_ptr on push; a word SHALL appear on rd_data with rd_valid high on the cycle after its push (one-cycle latency).
REQ-021 SHALL present rd_data = mem[rd_ptr] combinationally; rd_data is don't-care while rd_valid is low.
REQ-022 SHALL, on simultaneous push and pop with 0 < count < DEPTH, perform both and leave count unchanged.
REQ-023 SHALL, when full, accept a pop only (wr_ready low); count becomes DEPTH-1 and wr_ready rises next cycle.
REQ-024 SHALL, when empty, accept a push only (rd_valid low, no bypass); count becomes 1.
REQ-025 SHALL ignore wr_valid while wr_ready is low and rd_ready while rd_valid is low, with no state change and no error.
REQ-026 SHALL register almost_full and almost_empty from the next count value, so they align with count.

Reset
REQ-027 SHALL, on nRST low, asynchronously clear both pointers to 0, giving count=0, wr_ready=1, rd_valid=0, almost_empty=1, almost_full=0.
REQ-028 SHALL not reset RAM contents; a reset mid-operation discards all stored words.

Configuration
REQ-029 SHALL use macro FIFO_FLUSH_EN: when defined, flush high clears both pointers at the next edge, overriding any push or pop in that cycle, and outputs then match the reset state.
REQ-030 SHALL, without FIFO_FLUSH_EN, have no flush port and no flush logic.

Structure
REQ-031 SHALL place a shared package fifo_pkg holding the default DATA_W/DEPTH constants and a pointer-width helper function.
REQ-032 SHALL instantiate one sub-module fifo_ram: DEPTH x DATA_W storage, synchronous write port and asynchronous read port.

Verification (DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-033 SHALL cover: reset, then push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; wr_ready=0 after fourth push; almost_full=1 from count=3.
REQ-034 SHALL cover: pop four words from full -> rd_data 0x11,0x22,0x33,0x44 in order; rd_valid=0 and almost_empty=1 at the end.
REQ-035 SHALL cover: push and pop together for 10 cycles at count=2 -> count stays 2; the pointers wrap past 7 and data order is preserved.
REQ-036 SHALL cover: wr_valid=1 while full with rd_ready=1 -> one pop only this cycle; the held word is written on the next cycle.
REQ-037 SHALL cover: nRST pulsed low at count=3 mid-cycle -> count=0 and rd_valid=0 immediately, before any clock edge.
REQ-038 SHALL cover, with FIFO_FLUSH_EN: flush=1 with push at count=2 -> count=0 next cycle and the pushed word is discarded.
